vec_writeback_unit: RTL and testbench

- Writeback stage of the vector pipeline. It produces the register-file write port (RegWriteW, wa3w, wd3) that the decode stage's register file consumes.
- Arbitrates between two sources:
  - single-cycle vector ALU results;
  - vector loads, which arrive from data memory one 20-bit word per beat and are gathered lane by lane.
- A completed load is committed to the register file as one 8-lane write.
- Asserts stall back to the pipeline on write-port conflicts.

---
 rtl/vec_writeback_unit_pkg.sv | 20 ++
 rtl/vec_writeback_unit_if.sv | 34 +++
 rtl/vec_writeback_unit_lane_gather_buffer.sv | 37 +++
 rtl/vec_writeback_unit.sv | 92 +++++++++
 tb/tb_vec_writeback_unit.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vec_writeback_unit_pkg.sv
// Purpose : shared constants, vector type and writeback FSM state type for the
//           vector writeback unit.
// Contents: N (lane width), LANES (lanes per register), ADDR_W (register
//           address width), CNT_W (lane counter width), vec_t, wb_state_t.
package vec_pkg;

    localparam int N      = 20;
    localparam int LANES  = 8;
    localparam int ADDR_W = 4;
    localparam int CNT_W  = $clog2(LANES);

    typedef logic [LANES-1:0][N-1:0] vec_t;

    typedef enum logic [1:0] {
        IDLE,
        GATHER,
        COMMIT
    } wb_state_t;

endpackage

// File: rtl/vec_writeback_unit_if.sv
// Purpose : bundles the writeback unit's pipeline, memory and register-file
//           port signals.
// Modports: master - pipeline/memory side (drives alu_*, ld_*, mem_rvalid,
//                    mem_rdata; observes the rest)
//           slave  - writeback unit (drives mem_rready, stall, busy,
//                    RegWriteW, wa3w, wd3)
interface vec_writeback_unit_if;
    import vec_pkg::*;

    logic              alu_valid;
    logic [ADDR_W-1:0] alu_wa;
    vec_t              alu_data;
    logic              ld_start;
    logic [ADDR_W-1:0] ld_wa;
    logic              mem_rvalid;
    logic [N-1:0]      mem_rdata;
    logic              mem_rready;
    logic              stall;
    logic              busy;
    logic              RegWriteW;
    logic [ADDR_W-1:0] wa3w;
    vec_t              wd3;

    modport master (
        output alu_valid, alu_wa, alu_data, ld_start, ld_wa, mem_rvalid, mem_rdata,
        input  mem_rready, stall, busy, RegWriteW, wa3w, wd3
    );

    modport slave (
        input  alu_valid, alu_wa, alu_data, ld_start, ld_wa, mem_rvalid, mem_rdata,
        output mem_rready, stall, busy, RegWriteW, wa3w, wd3
    );

endinterface

// File: rtl/vec_writeback_unit_lane_gather_buffer.sv
// Purpose : collects one memory word per accepted beat into consecutive lanes
//           of a vector register image.
// Ports   : clk, rst (async, active high)
//           clear   - restart at lane 0
//           wr_en   - write wr_data into the current lane and advance
//           wr_data - memory word
//           data    - gathered vector
//           last    - current lane is the final lane
module lane_gather_buffer
    import vec_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         wr_en,
    input  logic [N-1:0] wr_data,
    output vec_t         data,
    output logic         last
);

    logic [CNT_W-1:0] cnt;

    assign last = (cnt == CNT_W'(LANES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            data <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (wr_en) begin
            data[cnt] <= wr_data;
            cnt       <= last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vec_writeback_unit.sv
// Purpose : vector writeback stage. Gathers vector loads lane by lane from
//           memory, commits them as one 8-lane register write, and arbitrates
//           the register-file write port against single-cycle ALU results.
// Ports   : clk - rising-edge clock
//           RST - asynchronous active-high reset
//           wb  - slave side of vec_writeback_unit_if (ALU result, load start,
//                 memory beat handshake, stall/busy, RegWriteW/wa3w/wd3)
module vec_writeback_unit
    import vec_pkg::*;
(
    input  logic                  clk,
    input  logic                  RST,
    vec_writeback_unit_if.slave   wb
);

    wb_state_t         state;
    wb_state_t         state_nxt;
    logic [ADDR_W-1:0] ld_addr;
    vec_t              gather_data;
    logic              last_lane;
    logic              gather_clear;
    logic              gather_wr;
    logic              alu_accept;

    lane_gather_buffer u_gather (
        .clk     (clk),
        .rst     (RST),
        .clear   (gather_clear),
        .wr_en   (gather_wr),
        .wr_data (wb.mem_rdata),
        .data    (gather_data),
        .last    (last_lane)
    );

    assign wb.busy       = (state != IDLE);
    assign wb.mem_rready = (state == GATHER);
    assign wb.stall      = (wb.alu_valid && state == COMMIT) ||
                           (wb.ld_start && state != IDLE);
    assign alu_accept    = wb.alu_valid && !wb.stall;

    always_comb begin
        state_nxt    = state;
        gather_clear = 1'b0;
        gather_wr    = 1'b0;
        case (state)
            IDLE: begin
                if (wb.ld_start) begin
                    state_nxt    = GATHER;
                    gather_clear = 1'b1;
                end
            end
            GATHER: begin
                if (wb.mem_rvalid) begin
                    gather_wr = 1'b1;
                    if (last_lane) state_nxt = COMMIT;
                end
            end
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            ld_addr <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && wb.ld_start) ld_addr <= wb.ld_wa;
        end
    end

    // Load commit wins the port; a colliding ALU result is held off by stall.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            wb.RegWriteW <= 1'b0;
            wb.wa3w      <= '0;
            wb.wd3       <= '0;
        end else if (state == COMMIT) begin
            wb.RegWriteW <= 1'b1;
            wb.wa3w      <= ld_addr;
            wb.wd3       <= gather_data;
        end else if (alu_accept) begin
            wb.RegWriteW <= 1'b1;
            wb.wa3w      <= wb.alu_wa;
            wb.wd3       <= wb.alu_data;
        end else begin
            wb.RegWriteW <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vec_writeback_unit.sv
module tb_vec_writeback_unit;
    import vec_pkg::*;

    logic clk = 1'b0;
    logic RST = 1'b1;
    int   total = 0;
    int   bad   = 0;

    vec_writeback_unit_if bus ();

    vec_writeback_unit dut (
        .clk (clk),
        .RST (RST),
        .wb  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        bus.alu_valid  = 1'b0;
        bus.alu_wa     = '0;
        bus.alu_data   = '0;
        bus.ld_start   = 1'b0;
        bus.ld_wa      = '0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
    endtask

    function automatic vec_t ramp(input logic [N-1:0] base);
        vec_t v;
        for (int unsigned k = 0; k < LANES; k++) v[k] = base + N'(k);
        return v;
    endfunction

    task automatic test_reset();
        idle_inputs();
        RST = 1'b1;
        settle();
        total++; if (bus.RegWriteW !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", bus.RegWriteW); end
        total++; if (bus.wa3w !== 4'h0) begin bad++; $display("FAIL reset_wa got=%h want=0", bus.wa3w); end
        total++; if (bus.wd3 !== vec_t'(0)) begin bad++; $display("FAIL reset_wd got=%h want=0", bus.wd3); end
        total++; if ({bus.busy, bus.mem_rready, bus.stall} !== 3'b000)
            begin bad++; $display("FAIL reset_ctl got=%b want=000", {bus.busy, bus.mem_rready, bus.stall}); end
        cyc();
        RST = 1'b0;
        cyc();
    endtask

    task automatic test_alu();
        vec_t exp = ramp(20'h00001);
        bus.alu_valid = 1'b1; bus.alu_wa = 4'd3; bus.alu_data = exp;
        cyc();
        bus.alu_valid = 1'b0; bus.alu_data = '0;
        settle();
        total++; if (bus.RegWriteW !== 1'b1) begin bad++; $display("FAIL alu_we got=%b want=1", bus.RegWriteW); end
        total++; if (bus.wa3w !== 4'd3) begin bad++; $display("FAIL alu_wa got=%h want=3", bus.wa3w); end
        total++; if (bus.wd3 !== exp) begin bad++; $display("FAIL alu_wd got=%h want=%h", bus.wd3, exp); end
        cyc();
        settle();
        total++; if (bus.RegWriteW !== 1'b0) begin bad++; $display("FAIL alu_we_drop got=%b want=0", bus.RegWriteW); end
        total++; if (bus.wd3 !== exp) begin bad++; $display("FAIL alu_wd_hold got=%h want=%h", bus.wd3, exp); end
        cyc();
    endtask

    task automatic test_back_to_back();
        vec_t exp = ramp(20'hA0000);
        bus.ld_start = 1'b1; bus.ld_wa = 4'd5;
        cyc();
        bus.ld_start = 1'b0;
        for (int unsigned k = 0; k < LANES; k++) begin
            bus.mem_rvalid = 1'b1; bus.mem_rdata = exp[k];
            settle();
            total++; if ({bus.busy, bus.mem_rready, bus.RegWriteW} !== 3'b110)
                begin bad++; $display("FAIL b2b_gather[%0d] busy/rready/we got=%b want=110", k, {bus.busy, bus.mem_rready, bus.RegWriteW}); end
            cyc();
        end
        bus.mem_rvalid = 1'b0;
        settle();
        total++; if ({bus.busy, bus.mem_rready, bus.RegWriteW} !== 3'b100)
            begin bad++; $display("FAIL b2b_commit busy/rready/we got=%b want=100", {bus.busy, bus.mem_rready, bus.RegWriteW}); end
        cyc();
        settle();
        total++; if (bus.RegWriteW !== 1'b1) begin bad++; $display("FAIL b2b_we got=%b want=1", bus.RegWriteW); end
        total++; if (bus.wa3w !== 4'd5) begin bad++; $display("FAIL b2b_wa got=%h want=5", bus.wa3w); end
        total++; if (bus.wd3 !== exp) begin bad++; $display("FAIL b2b_wd got=%h want=%h", bus.wd3, exp); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL b2b_idle busy got=%b want=0", bus.busy); end
        cyc();
        settle();
        total++; if (bus.RegWriteW !== 1'b0) begin bad++; $display("FAIL b2b_we_drop got=%b want=0", bus.RegWriteW); end
    endtask

    task automatic test_bubbled();
        vec_t exp = ramp(20'hA0000);
        bus.ld_start = 1'b1; bus.ld_wa = 4'd5;
        cyc();
        bus.ld_start = 1'b0;
        for (int unsigned c = 1; c <= 16; c++) begin
            bus.mem_rvalid = (c % 2 == 0);
            bus.mem_rdata  = (c % 2 == 0) ? exp[c/2 - 1] : 20'hFFFFF;
            settle();
            total++; if (bus.RegWriteW !== 1'b0) begin bad++; $display("FAIL bub_early_we cycle=%0d got=%b want=0", c, bus.RegWriteW); end
            cyc();
        end
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 20'h5A5A5;
        settle();
        total++; if ({bus.busy, bus.mem_rready} !== 2'b10)
            begin bad++; $display("FAIL bub_commit busy/rready got=%b want=10", {bus.busy, bus.mem_rready}); end
        cyc();
        settle();
        total++; if (bus.RegWriteW !== 1'b1) begin bad++; $display("FAIL bub_we got=%b want=1", bus.RegWriteW); end
        total++; if (bus.wa3w !== 4'd5) begin bad++; $display("FAIL bub_wa got=%h want=5", bus.wa3w); end
        total++; if (bus.wd3 !== exp) begin bad++; $display("FAIL bub_wd got=%h want=%h", bus.wd3, exp); end
        cyc();
        settle();
        total++; if ({bus.RegWriteW, bus.busy, bus.mem_rready} !== 3'b000)
            begin bad++; $display("FAIL bub_ignored we/busy/rready got=%b want=000", {bus.RegWriteW, bus.busy, bus.mem_rready}); end
        total++; if (bus.wd3 !== exp) begin bad++; $display("FAIL bub_wd_hold got=%h want=%h", bus.wd3, exp); end
        bus.mem_rvalid = 1'b0;
        cyc();
    endtask

    task automatic test_conflict();
        vec_t ld  = ramp(20'h70000);
        vec_t alu = ramp(20'h22220);
        bus.ld_start = 1'b1; bus.ld_wa = 4'd7;
        cyc();
        bus.ld_start = 1'b0;
        for (int unsigned k = 0; k < LANES; k++) begin
            bus.mem_rvalid = 1'b1; bus.mem_rdata = ld[k];
            cyc();
        end
        bus.mem_rvalid = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_wa = 4'd2; bus.alu_data = alu;
        settle();
        total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL conf_stall got=%b want=1", bus.stall); end
        cyc();
        settle();
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL conf_unstall got=%b want=0", bus.stall); end
        total++; if ({bus.RegWriteW, bus.wa3w} !== {1'b1, 4'd7})
            begin bad++; $display("FAIL conf_ld_write we/wa got=%b/%h want=1/7", bus.RegWriteW, bus.wa3w); end
        total++; if (bus.wd3 !== ld) begin bad++; $display("FAIL conf_ld_wd got=%h want=%h", bus.wd3, ld); end
        cyc();
        bus.alu_valid = 1'b0;
        settle();
        total++; if ({bus.RegWriteW, bus.wa3w} !== {1'b1, 4'd2})
            begin bad++; $display("FAIL conf_alu_write we/wa got=%b/%h want=1/2", bus.RegWriteW, bus.wa3w); end
        total++; if (bus.wd3 !== alu) begin bad++; $display("FAIL conf_alu_wd got=%h want=%h", bus.wd3, alu); end
        cyc();
        settle();
        total++; if (bus.RegWriteW !== 1'b0) begin bad++; $display("FAIL conf_we_drop got=%b want=0", bus.RegWriteW); end
    endtask

    task automatic test_second_start();
        vec_t first  = ramp(20'hB0000);
        vec_t second = ramp(20'hC0000);
        bus.ld_start = 1'b1; bus.ld_wa = 4'd1;
        cyc();
        bus.ld_wa = 4'd9;
        for (int unsigned c = 1; c <= 9; c++) begin
            bus.mem_rvalid = (c <= 8);
            bus.mem_rdata  = (c <= 8) ? first[c-1] : 20'h0;
            settle();
            total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL second_stall cycle=%0d got=%b want=1", c, bus.stall); end
            cyc();
        end
        bus.mem_rvalid = 1'b0;
        settle();
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL second_unstall got=%b want=0", bus.stall); end
        total++; if ({bus.RegWriteW, bus.wa3w} !== {1'b1, 4'd1})
            begin bad++; $display("FAIL second_first_write we/wa got=%b/%h want=1/1", bus.RegWriteW, bus.wa3w); end
        total++; if (bus.wd3 !== first) begin bad++; $display("FAIL second_first_wd got=%h want=%h", bus.wd3, first); end
        cyc();
        bus.ld_start = 1'b0;
        settle();
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL second_accepted busy got=%b want=1", bus.busy); end
        for (int unsigned k = 0; k < LANES; k++) begin
            bus.mem_rvalid = 1'b1; bus.mem_rdata = second[k];
            cyc();
        end
        bus.mem_rvalid = 1'b0;
        cyc();
        settle();
        total++; if ({bus.RegWriteW, bus.wa3w} !== {1'b1, 4'd9})
            begin bad++; $display("FAIL second_write we/wa got=%b/%h want=1/9", bus.RegWriteW, bus.wa3w); end
        total++; if (bus.wd3 !== second) begin bad++; $display("FAIL second_wd got=%h want=%h", bus.wd3, second); end
        cyc();
    endtask

    task automatic test_reset_mid();
        vec_t fresh = ramp(20'hE0000);
        int   writes = 0;
        bus.ld_start = 1'b1; bus.ld_wa = 4'd4;
        cyc();
        bus.ld_start = 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            bus.mem_rvalid = 1'b1; bus.mem_rdata = 20'hD0000 + 20'(k);
            cyc();
        end
        bus.mem_rdata = 20'h12345;
        #1;
        RST = 1'b1;
        #1;
        total++; if ({bus.RegWriteW, bus.busy, bus.mem_rready, bus.stall} !== 4'b0000)
            begin bad++; $display("FAIL rstmid_ctl we/busy/rready/stall got=%b want=0000", {bus.RegWriteW, bus.busy, bus.mem_rready, bus.stall}); end
        total++; if ({bus.wa3w, bus.wd3} !== '0) begin bad++; $display("FAIL rstmid_data wa=%h wd=%h want=0", bus.wa3w, bus.wd3); end
        cyc();
        RST = 1'b0;
        bus.mem_rvalid = 1'b0;
        for (int unsigned c = 0; c < 12; c++) begin
            settle();
            if (bus.RegWriteW === 1'b1) writes++;
            cyc();
        end
        total++; if (writes != 0) begin bad++; $display("FAIL rstmid_no_write count got=%0d want=0", writes); end
        bus.ld_start = 1'b1; bus.ld_wa = 4'd6;
        cyc();
        bus.ld_start = 1'b0;
        writes = 0;
        for (int unsigned k = 0; k < LANES; k++) begin
            bus.mem_rvalid = 1'b1; bus.mem_rdata = fresh[k];
            settle();
            if (bus.RegWriteW === 1'b1) writes++;
            cyc();
        end
        bus.mem_rvalid = 1'b0;
        settle();
        total++; if ({writes != 0, bus.busy} !== 2'b01)
            begin bad++; $display("FAIL rstmid_fresh_gather early_writes=%0d busy=%b want=0/1", writes, bus.busy); end
        cyc();
        settle();
        total++; if ({bus.RegWriteW, bus.wa3w} !== {1'b1, 4'd6})
            begin bad++; $display("FAIL rstmid_fresh_write we/wa got=%b/%h want=1/6", bus.RegWriteW, bus.wa3w); end
        total++; if (bus.wd3 !== fresh) begin bad++; $display("FAIL rstmid_fresh_wd got=%h want=%h", bus.wd3, fresh); end
        cyc();
    endtask

    // Reference: a load is a list of words collected while gathering; once the
    // list holds LANES words the next cycle is the commit.
    task automatic test_random();
        logic [N-1:0]      words[$];
        logic              loading = 1'b0;
        logic              committing = 1'b0;
        logic [ADDR_W-1:0] ld_addr = '0;
        logic              m_we = 1'b0;
        logic [ADDR_W-1:0] m_wa = '0;
        vec_t              m_wd = '0;
        logic              hold = 1'b0;
        logic              e_busy, e_rready, e_stall;
        int                errs = 0;

        idle_inputs();
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        for (int unsigned c = 0; c < 1500; c++) begin
            if (!hold) begin
                bus.alu_valid = ($urandom % 3 == 0);
                bus.alu_wa    = 4'($urandom);
                for (int unsigned k = 0; k < LANES; k++) bus.alu_data[k] = N'($urandom);
                bus.ld_start  = ($urandom % 6 == 0);
                bus.ld_wa     = 4'($urandom);
            end
            bus.mem_rvalid = ($urandom % 2 == 0);
            bus.mem_rdata  = N'($urandom);
            settle();

            e_busy   = loading || committing;
            e_rready = loading;
            e_stall  = (bus.alu_valid && committing) || (bus.ld_start && e_busy);

            total++; if ({bus.busy, bus.mem_rready, bus.stall} !== {e_busy, e_rready, e_stall}) begin
                bad++; errs++;
                if (errs < 10) $display("FAIL rand_ctl cycle=%0d busy/rready/stall got=%b want=%b", c,
                                        {bus.busy, bus.mem_rready, bus.stall}, {e_busy, e_rready, e_stall});
            end
            total++; if ({bus.RegWriteW, bus.wa3w, bus.wd3} !== {m_we, m_wa, m_wd}) begin
                bad++; errs++;
                if (errs < 10) $display("FAIL rand_port cycle=%0d we/wa got=%b/%h want=%b/%h wd got=%h want=%h", c,
                                        bus.RegWriteW, bus.wa3w, m_we, m_wa, bus.wd3, m_wd);
            end

            hold = e_stall;
            if (committing) begin
                m_we = 1'b1; m_wa = ld_addr;
                for (int unsigned k = 0; k < LANES; k++) m_wd[k] = words[k];
                committing = 1'b0;
                words.delete();
            end else if (bus.alu_valid && !e_stall) begin
                m_we = 1'b1; m_wa = bus.alu_wa; m_wd = bus.alu_data;
            end else begin
                m_we = 1'b0;
            end
            if (loading && bus.mem_rvalid) begin
                words.push_back(bus.mem_rdata);
                if (words.size() == LANES) begin
                    loading    = 1'b0;
                    committing = 1'b1;
                end
            end
            if (!e_busy && bus.ld_start) begin
                loading = 1'b1;
                ld_addr = bus.ld_wa;
                words.delete();
            end
            cyc();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_alu();
        test_back_to_back();
        test_bubbled();
        test_conflict();
        test_second_start();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
